// File: rtl/np_seq_ctrl.sv
// Fetch/decode/execute sequencer for the np 32-bit datapath.
// Owns pc/ir/mdr, runs the memory req/ack handshake with an ack timeout, and
// issues one-cycle ALU-launch and register-file write strobes. Outputs are
// registered from the next-state values so they line up with state_o.
module np_seq_ctrl #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned ADDRSIZE    = 12,
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  input  logic [WIDTH-1:0]    mem_rdata_i,
  input  logic                mem_ack_i,
  input  logic [4:0]          psr_i,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [ADDRSIZE-1:0] mem_addr_o,
  output logic [WIDTH-1:0]    ir_o,
  output logic [ADDRSIZE-1:0] pc_o,
  output logic [WIDTH-1:0]    mdr_o,
  output logic                alu_go_o,
  output logic                rf_we_o,
  output logic [1:0]          wb_sel_o,
  output logic [2:0]          state_o,
  output logic                halted_o,
  output logic                err_o
);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFetch  = 3'd1,
    StDecode = 3'd2,
    StMemRd  = 3'd3,
    StExec   = 3'd4,
    StMemWr  = 3'd5,
    StWb     = 3'd6,
    StHalt   = 3'd7
  } state_e;

  localparam logic [7:0] WaitLast = 8'(ACK_TIMEOUT - 1);

  state_e              state_q, state_d;
  logic [ADDRSIZE-1:0] pc_q, pc_d;
  logic [WIDTH-1:0]    ir_q, ir_d;
  logic [WIDTH-1:0]    mdr_q, mdr_d;
  logic [1:0]          wb_sel_q, wb_sel_d;
  logic                err_q, err_d;
  logic [7:0]          wait_q, wait_d;

  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDRSIZE-1:0] mem_addr_q, mem_addr_d;
  logic                alu_go_q, rf_we_q, halted_q;

  logic [3:0] opcode;
  logic       cond_ok;
  logic       timed_out;

  assign opcode    = ir_q[31:28];
  assign timed_out = (wait_q == WaitLast);

  // Branch condition evaluated against psr while in DECODE.
  always_comb begin
    cond_ok = 1'b0;
    unique case (ir_q[27:24])
      4'h0:    cond_ok = 1'b1;
      4'h1:    cond_ok = psr_i[0];
      4'h2:    cond_ok = psr_i[1];
      4'h3:    cond_ok = psr_i[2];
      4'h4:    cond_ok = psr_i[3];
      4'h5:    cond_ok = psr_i[4];
      default: cond_ok = 1'b0;
    endcase
  end

  // Next-state and datapath-register update.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    mdr_d    = mdr_q;
    wb_sel_d = wb_sel_q;
    err_d    = err_q;
    unique case (state_q)
      StIdle: if (start_i) state_d = StFetch;
      StFetch: begin
        if (mem_ack_i) begin
          ir_d    = mem_rdata_i;
          pc_d    = pc_q + ADDRSIZE'(1);
          state_d = StDecode;
        end else if (timed_out) begin
          err_d   = 1'b1;
          state_d = StHalt;
        end
      end
      StDecode: begin
        unique case (opcode)
          4'h1: begin
            if (cond_ok) pc_d = ir_q[ADDRSIZE-1:0];
            state_d = StFetch;
          end
          4'h2: begin
            if (ir_q[27]) begin
              wb_sel_d = 2'd2;
              state_d  = StWb;
            end else begin
              state_d  = StMemRd;
            end
          end
          4'h3:                                        state_d = StMemWr;
          4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA:    state_d = StExec;
          4'hB:                                        state_d = StHalt;
          default:                                     state_d = StFetch;
        endcase
      end
      StMemRd: begin
        if (mem_ack_i) begin
          mdr_d    = mem_rdata_i;
          wb_sel_d = 2'd1;
          state_d  = StWb;
        end else if (timed_out) begin
          err_d   = 1'b1;
          state_d = StHalt;
        end
      end
      StExec: begin
        if (opcode == 4'h6) begin
          state_d = StFetch;
        end else begin
          wb_sel_d = 2'd0;
          state_d  = StWb;
        end
      end
      StMemWr: begin
        if (mem_ack_i) begin
          state_d = StFetch;
        end else if (timed_out) begin
          err_d   = 1'b1;
          state_d = StHalt;
        end
      end
      StWb:    state_d = StFetch;
      StHalt:  state_d = StHalt;
      default: state_d = StIdle;
    endcase
    // Any state change restarts the ack wait count.
    wait_d = (state_d != state_q) ? 8'd0 : wait_q + 8'd1;
  end

  // Memory-port outputs for the state being entered.
  always_comb begin
    mem_req_d  = 1'b0;
    mem_we_d   = 1'b0;
    mem_addr_d = pc_d;
    unique case (state_d)
      StFetch: mem_req_d = 1'b1;
      StMemRd: begin
        mem_req_d  = 1'b1;
        mem_addr_d = ir_d[23:12];
      end
      StMemWr: begin
        mem_req_d  = 1'b1;
        mem_we_d   = 1'b1;
        mem_addr_d = ir_d[ADDRSIZE-1:0];
      end
      default: ;
    endcase
  end

  // State, datapath registers and registered control outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      pc_q       <= '0;
      ir_q       <= '0;
      mdr_q      <= '0;
      wb_sel_q   <= 2'd0;
      err_q      <= 1'b0;
      wait_q     <= 8'd0;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      alu_go_q   <= 1'b0;
      rf_we_q    <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      mdr_q      <= mdr_d;
      wb_sel_q   <= wb_sel_d;
      err_q      <= err_d;
      wait_q     <= wait_d;
      mem_req_q  <= mem_req_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      alu_go_q   <= (state_d == StExec);
      rf_we_q    <= (state_d == StWb);
      halted_q   <= (state_d == StHalt);
    end
  end

  assign mem_req_o  = mem_req_q;
  assign mem_we_o   = mem_we_q;
  assign mem_addr_o = mem_addr_q;
  assign ir_o       = ir_q;
  assign pc_o       = pc_q;
  assign mdr_o      = mdr_q;
  assign alu_go_o   = alu_go_q;
  assign rf_we_o    = rf_we_q;
  assign wb_sel_o   = wb_sel_q;
  assign state_o    = state_q;
  assign halted_o   = halted_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_np_seq_ctrl.sv
// Directed bench for np_seq_ctrl with a 4K-word memory model and
// programmable ack latency.
module tb_np_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic [4:0]  psr;
  logic        mem_req, mem_we, alu_go, rf_we, halted, err;
  logic [11:0] mem_addr, pc;
  logic [31:0] ir, mdr;
  logic [1:0]  wb_sel;
  logic [2:0]  state;

  logic [31:0] mem [4096];
  int          ack_delay;
  bit          ack_never;
  int          wait_cnt;
  int          n_tests = 0;
  int          n_fail  = 0;

  np_seq_ctrl dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .start_i     (start),
    .mem_rdata_i (mem_rdata),
    .mem_ack_i   (mem_ack),
    .psr_i       (psr),
    .mem_req_o   (mem_req),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .ir_o        (ir),
    .pc_o        (pc),
    .mdr_o       (mdr),
    .alu_go_o    (alu_go),
    .rf_we_o     (rf_we),
    .wb_sel_o    (wb_sel),
    .state_o     (state),
    .halted_o    (halted),
    .err_o       (err)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];
  assign mem_ack   = mem_req && !ack_never && (wait_cnt >= ack_delay);

  always @(posedge clk) begin
    if (!mem_req || mem_ack) wait_cnt <= 0;
    else                     wait_cnt <= wait_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Assert reset and clear memory; caller loads a program then calls release_rst.
  task automatic hold_rst(input logic [4:0] psr_v);
    rst_n     = 1'b0;
    start     = 1'b1;
    ack_delay = 0;
    ack_never = 1'b0;
    psr       = psr_v;
    for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
  endtask

  task automatic release_rst();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    // 1: NOP, HLT
    hold_rst(5'h00);
    mem[0] = 32'h0000_0000;
    mem[1] = 32'hB000_0000;
    #1;
    check_eq("rst_state", {29'h0, state}, 32'd0);
    check_eq("rst_req", {31'h0, mem_req}, 32'd0);
    check_eq("rst_pc", {20'h0, pc}, 32'd0);
    check_eq("rst_ir_mdr", ir | mdr, 32'd0);
    check_eq("rst_flags", {26'h0, wb_sel, alu_go, rf_we, halted, err}, 32'd0);
    release_rst();
    step(1);
    check_eq("t1_fetch0_state", {29'h0, state}, 32'd1);
    check_eq("t1_fetch0_addr", {20'h0, mem_addr}, 32'd0);
    check_eq("t1_fetch0_req", {30'h0, mem_req, mem_we}, 32'b10);
    step(2);
    check_eq("t1_fetch1_addr", {20'h0, mem_addr}, 32'd1);
    step(2);
    check_eq("t1_halt_state", {29'h0, state}, 32'd7);
    check_eq("t1_halted", {30'h0, halted, mem_req}, 32'b10);
    check_eq("t1_pc", {20'h0, pc}, 32'd2);
    check_eq("t1_err", {31'h0, err}, 32'd0);

    // 2: LD imm 0x2A -> R3, ADD -> R5, CMP
    hold_rst(5'h00);
    mem[0] = 32'h2802_A003;
    mem[1] = 32'h4000_0005;
    mem[2] = 32'h6000_0001;
    release_rst();
    step(3);
    check_eq("t2_ldi_wb", {29'h0, state}, 32'd6);
    check_eq("t2_ldi_strobes", {28'h0, rf_we, alu_go, wb_sel}, 32'b1010);
    check_eq("t2_ldi_waddr", {28'h0, ir[3:0]}, 32'd3);
    step(3);
    check_eq("t2_add_exec", {29'h0, state}, 32'd4);
    check_eq("t2_add_go", {30'h0, alu_go, rf_we}, 32'b10);
    check_eq("t2_add_op", {28'h0, ir[31:28]}, 32'd4);
    step(1);
    check_eq("t2_add_wb", {28'h0, rf_we, alu_go, wb_sel}, 32'b1000);
    step(1);
    check_eq("t2_add_done", {30'h0, rf_we, alu_go}, 32'd0);
    check_eq("t2_fetch2_addr", {20'h0, mem_addr}, 32'd2);
    step(2);
    check_eq("t2_cmp_go", {30'h0, alu_go, rf_we}, 32'b10);
    step(1);
    check_eq("t2_cmp_nowb", {28'h0, rf_we, state}, {28'h0, 1'b0, 3'd1});
    check_eq("t2_cmp_addr", {20'h0, mem_addr}, 32'd3);

    // 3: BRA on ZERO, taken / not taken, and a never-taken code
    hold_rst(5'b01000);
    mem[0] = 32'h1400_0100;
    release_rst();
    step(3);
    check_eq("t3_taken_addr", {20'h0, mem_addr}, 32'h100);
    check_eq("t3_taken_pc", {20'h0, pc}, 32'h100);
    hold_rst(5'b10111);
    mem[0] = 32'h1400_0100;
    release_rst();
    step(3);
    check_eq("t3_nottaken_addr", {20'h0, mem_addr}, 32'd1);
    hold_rst(5'b11111);
    mem[0] = 32'h1700_0100;
    release_rst();
    step(3);
    check_eq("t3_never_addr", {20'h0, mem_addr}, 32'd1);
    hold_rst(5'b00001);
    mem[0] = 32'h1100_0ABC;
    release_rst();
    step(3);
    check_eq("t3_carry_addr", {20'h0, mem_addr}, 32'hABC);

    // 4: STR with a slow ack
    hold_rst(5'h00);
    mem[0] = 32'h3000_0ABC;
    release_rst();
    step(2);
    ack_delay = 5;
    for (int i = 0; i < 5; i++) begin
      step(1);
      check_eq("t4_str_hold", {16'h0, mem_req, mem_we, alu_go, rf_we, mem_addr},
               {16'h0, 4'b1100, 12'hABC});
    end
    step(2);
    check_eq("t4_str_done", {28'h0, mem_we, state}, {28'h0, 1'b0, 3'd1});
    check_eq("t4_next_addr", {20'h0, mem_addr}, 32'd1);

    // 5: ack never arrives
    hold_rst(5'h00);
    ack_never = 1'b1;
    release_rst();
    step(15);
    check_eq("t5_still_wait", {29'h0, mem_req, err, halted}, 32'b100);
    step(1);
    check_eq("t5_timeout", {29'h0, mem_req, err, halted}, 32'b011);
    check_eq("t5_state", {29'h0, state}, 32'd7);

    // LD from memory
    hold_rst(5'h00);
    mem[0]     = 32'h2012_3007;
    mem[12'h123] = 32'hDEAD_BEEF;
    release_rst();
    step(3);
    check_eq("ldm_addr", {19'h0, mem_req, mem_addr}, {19'h0, 1'b1, 12'h123});
    step(1);
    check_eq("ldm_mdr", mdr, 32'hDEAD_BEEF);
    check_eq("ldm_wb", {28'h0, rf_we, alu_go, wb_sel}, 32'b1001);

    // 6: async reset during a stalled MEMRD
    hold_rst(5'h00);
    mem[0] = 32'h2012_3007;
    release_rst();
    step(2);
    ack_never = 1'b1;
    step(2);
    check_eq("t6_waiting", {29'h0, state}, 32'd3);
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("t6_async_req", {31'h0, mem_req}, 32'd0);
    check_eq("t6_async_state", {29'h0, state}, 32'd0);
    check_eq("t6_async_pc", {20'h0, pc}, 32'd0);

    // 7: pc wraps after fetching 0xFFF
    hold_rst(5'h00);
    mem[0] = 32'h1000_0FFF;
    release_rst();
    step(3);
    check_eq("t7_fetch_fff", {20'h0, mem_addr}, 32'hFFF);
    step(1);
    check_eq("t7_pc_wrap", {20'h0, pc}, 32'd0);
    step(1);
    check_eq("t7_fetch_0", {20'h0, mem_addr}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
